// File: rtl/projeto_plate_gate.sv
// Car-park plate validator: classifies a six-character plate into digit/letter pairs,
// checks the format, and opens the barrier on an alternating-parity day rule.
module projeto_plate_gate (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] E,
  input  logic [3:0] F,
  input  logic [2:0] Dia,
  output logic       Barreira1,
  output logic       MatrVal
);

  logic [3:0] ch [6];
  logic [5:0] is_digit;
  logic [2:0] pair_n;
  logic [2:0] pair_l;

  assign ch[0] = A;
  assign ch[1] = B;
  assign ch[2] = C;
  assign ch[3] = D;
  assign ch[4] = E;
  assign ch[5] = F;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_class
      assign is_digit[gi] = (ch[gi] <= 4'd9);
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_pair
      assign pair_n[gi] = is_digit[2*gi] & is_digit[2*gi+1];
      assign pair_l[gi] = ~is_digit[2*gi] & ~is_digit[2*gi+1];
    end
  endgenerate

  logic fmt_ok;
  logic ctrl_odd;
  logic day_ok;
  logic matr_d, matr_q;
  logic barr_d, barr_q;

  // Only the control digit's LSB matters, so select its parity directly.
  always_comb begin
    fmt_ok   = 1'b0;
    ctrl_odd = 1'b0;
    if ((pair_n | pair_l) == 3'b111) begin
      case ({pair_n[0], pair_n[1], pair_n[2]})
        3'b110:  begin fmt_ok = 1'b1; ctrl_odd = D[0]; end  // N-N-L
        3'b101:  begin fmt_ok = 1'b1; ctrl_odd = F[0]; end  // N-L-N
        3'b011:  begin fmt_ok = 1'b1; ctrl_odd = F[0]; end  // L-N-N
        3'b010:  begin fmt_ok = 1'b1; ctrl_odd = D[0]; end  // L-N-L
        default: begin fmt_ok = 1'b0; ctrl_odd = 1'b0; end
      endcase
    end
  end

  always_comb begin
    day_ok = 1'b0;
    case (Dia)
      3'd1, 3'd3, 3'd5: day_ok = ~ctrl_odd;
      3'd2, 3'd4, 3'd6: day_ok = ctrl_odd;
      3'd7:             day_ok = 1'b1;
      default:          day_ok = 1'b0;
    endcase
  end

  assign matr_d = fmt_ok;
  assign barr_d = fmt_ok & day_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matr_q <= 1'b0;
      barr_q <= 1'b0;
    end else begin
      matr_q <= matr_d;
      barr_q <= barr_d;
    end
  end

  assign MatrVal   = matr_q;
  assign Barreira1 = barr_q;

endmodule

// File: tb/tb_projeto_plate_gate.sv
// Bench for projeto_plate_gate: directed scenarios with hand-derived results plus
// random plates checked against a pattern-string reference model.
module tb_projeto_plate_gate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A, B, C, D, E, F;
  logic [2:0] Dia;
  logic       Barreira1, MatrVal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  projeto_plate_gate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .E         (E),
    .F         (F),
    .Dia       (Dia),
    .Barreira1 (Barreira1),
    .MatrVal   (MatrVal)
  );

  // Reference: {MatrVal, Barreira1} from the plate's pair pattern and its last digit.
  function automatic logic [1:0] ref_model(input logic [23:0] p, input logic [2:0] d);
    string      pat;
    logic [3:0] c1, c2, cd;
    logic       v, b, found;
    pat = "";
    for (int k = 0; k < 3; k++) begin
      c1 = p[23-8*k -: 4];
      c2 = p[19-8*k -: 4];
      if (c1 <= 9 && c2 <= 9)      pat = {pat, "N"};
      else if (c1 > 9 && c2 > 9)   pat = {pat, "L"};
      else                         pat = {pat, "X"};
    end
    v = (pat == "NNL") || (pat == "NLN") || (pat == "LNN") || (pat == "LNL");
    cd = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!found && p[4*i +: 4] <= 9) begin
        cd = p[4*i +: 4];
        found = 1'b1;
      end
    end
    b = 1'b0;
    if (v) begin
      if (d == 7)                                b = 1'b1;
      else if ((d == 1 || d == 3 || d == 5) && (cd % 2 == 0)) b = 1'b1;
      else if ((d == 2 || d == 4 || d == 6) && (cd % 2 == 1)) b = 1'b1;
    end
    return {v, b};
  endfunction

  task automatic set_in(input logic [23:0] p, input logic [2:0] d);
    {A, B, C, D, E, F} = p;
    Dia = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    set_in(24'hBD9752, 3'd5);
    #1;
    checks++;
    $display("reset_async: out=%b%b", MatrVal, Barreira1);
    if ({MatrVal, Barreira1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: got %b%b expected 00", MatrVal, Barreira1);
    end
    step();
    checks++;
    $display("reset_held: out=%b%b", MatrVal, Barreira1);
    if ({MatrVal, Barreira1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_held: got %b%b expected 00", MatrVal, Barreira1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    $display("reset_release: BD9752 dia=5 out=%b%b", MatrVal, Barreira1);
    if ({MatrVal, Barreira1} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: got %b%b expected 11", MatrVal, Barreira1);
    end
  endtask

  task automatic test_mixed();
    logic [2:0] days [3] = '{3'd1, 3'd2, 3'd7};
    for (int i = 0; i < 3; i++) begin
      set_in(24'h34A366, days[i]);
      step();
      checks++;
      $display("mixed: 34A366 dia=%0d out=%b%b", days[i], MatrVal, Barreira1);
      if ({MatrVal, Barreira1} !== 2'b00) begin
        errors++;
        $display("FAIL mixed dia=%0d: got %b%b expected 00", days[i], MatrVal, Barreira1);
      end
    end
  endtask

  task automatic test_all_same();
    logic [23:0] plates [6] = '{24'hBBABFF, 24'hBBABFF, 24'hBBABFF,
                                24'h123468, 24'h123468, 24'h123468};
    logic [2:0]  days   [6] = '{3'd1, 3'd2, 3'd7, 3'd3, 3'd4, 3'd7};
    for (int i = 0; i < 6; i++) begin
      set_in(plates[i], days[i]);
      step();
      checks++;
      $display("all_same: %h dia=%0d out=%b%b", plates[i], days[i], MatrVal, Barreira1);
      if ({MatrVal, Barreira1} !== 2'b00) begin
        errors++;
        $display("FAIL all_same %h dia=%0d: got %b%b expected 00",
                 plates[i], days[i], MatrVal, Barreira1);
      end
    end
  endtask

  task automatic test_parity();
    logic [2:0] days [4] = '{3'd5, 3'd6, 3'd7, 3'd0};
    logic [1:0] exp  [4] = '{2'b11, 2'b10, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      set_in(24'hBD9752, days[i]);
      step();
      checks++;
      $display("parity: BD9752 dia=%0d out=%b%b", days[i], MatrVal, Barreira1);
      if ({MatrVal, Barreira1} !== exp[i]) begin
        errors++;
        $display("FAIL parity dia=%0d: got %b%b expected %b",
                 days[i], MatrVal, Barreira1, exp[i]);
      end
    end
  endtask

  task automatic test_formats();
    logic [23:0] plates [5] = '{24'h12AB34, 24'h12AB34, 24'h5703CC, 24'h5703CC, 24'hAA29FE};
    logic [2:0]  days   [5] = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd4};
    logic [1:0]  exp    [5] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    for (int i = 0; i < 5; i++) begin
      set_in(plates[i], days[i]);
      step();
      checks++;
      $display("formats: %h dia=%0d out=%b%b", plates[i], days[i], MatrVal, Barreira1);
      if ({MatrVal, Barreira1} !== exp[i]) begin
        errors++;
        $display("FAIL formats %h dia=%0d: got %b%b expected %b",
                 plates[i], days[i], MatrVal, Barreira1, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] prev = {MatrVal, Barreira1};
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_in(24'hBD9752, 3'd5); exp = 2'b11; end
      else            begin set_in(24'h34A366, 3'd5); exp = 2'b00; end
      #3;
      checks++;
      if ({MatrVal, Barreira1} !== prev) begin
        errors++;
        $display("FAIL b2b_hold %0d: got %b%b expected %b", i, MatrVal, Barreira1, prev);
      end
      step();
      checks++;
      $display("b2b: cycle %0d out=%b%b", i, MatrVal, Barreira1);
      if ({MatrVal, Barreira1} !== exp) begin
        errors++;
        $display("FAIL b2b %0d: got %b%b expected %b", i, MatrVal, Barreira1, exp);
      end
      prev = exp;
    end
    // Outputs are 00 now; load a valid result, then reset between edges.
    set_in(24'hBD9752, 3'd7);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    $display("b2b_reset: out=%b%b", MatrVal, Barreira1);
    if ({MatrVal, Barreira1} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_reset: got %b%b expected 00", MatrVal, Barreira1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    $display("b2b_recover: out=%b%b", MatrVal, Barreira1);
    if ({MatrVal, Barreira1} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_recover: got %b%b expected 11", MatrVal, Barreira1);
    end
  endtask

  function automatic logic [3:0] rnd_char(input logic letter);
    return letter ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
  endfunction

  task automatic test_random();
    logic [23:0] p;
    logic [2:0]  d;
    logic [1:0]  exp;
    int          kind;
    logic        lo;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++) begin
        kind = $urandom_range(0, 9);
        if (kind < 4)      begin p[23-8*k -: 4] = rnd_char(1'b0); p[19-8*k -: 4] = rnd_char(1'b0); end
        else if (kind < 8) begin p[23-8*k -: 4] = rnd_char(1'b1); p[19-8*k -: 4] = rnd_char(1'b1); end
        else begin
          lo = 1'($urandom_range(0, 1));
          p[23-8*k -: 4] = rnd_char(lo);
          p[19-8*k -: 4] = rnd_char(~lo);
        end
      end
      d = 3'($urandom_range(0, 7));
      exp = ref_model(p, d);
      set_in(p, d);
      step();
      checks++;
      $display("random %0d: %h dia=%0d out=%b%b exp=%b", n, p, d, MatrVal, Barreira1, exp);
      if ({MatrVal, Barreira1} !== exp) begin
        errors++;
        $display("FAIL random %h dia=%0d: got %b%b expected %b", p, d, MatrVal, Barreira1, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_all_same();
    test_parity();
    test_formats();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
